// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the ARM-subset pipeline.
// Holds datapath width, the bubble instruction, the sequential PC step,
// the "always" condition code and the opcode-class encoding used by decode.
// Also defines the per-cycle mode of the fetch stage.
package fetch_stage_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;
    localparam int PC_STEP = 4;

    // Condition field value meaning "execute unconditionally".
    localparam logic [3:0] COND_AL = 4'b1110;

    // Instruction class in bits [27:26].
    typedef enum logic [1:0] {
        OPC_DP     = 2'b00,
        OPC_MEM    = 2'b01,
        OPC_BRANCH = 2'b10
    } opclass_t;

    // Fetch behaviour for the current cycle, derived from the inputs only.
    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_HOLD     = 2'b01,
        MODE_REDIRECT = 2'b10
    } fetch_mode_t;

    function automatic logic [1:0] instr_class(input logic [DATA_WIDTH-1:0] instr);
        return instr[27:26];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its surroundings.
// master: fetch stage side (drives imem_addr and the IF/ID outputs).
// slave : environment side (instruction memory, hazard unit, EXE branch
//         resolution and the decode stage).
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                  freeze;
    logic                  branch_taken;
    logic [DATA_WIDTH-1:0] branch_addr;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_data;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_instr;
    logic                  id_valid;
    logic [31:0]           fetch_count;

    modport master (
        input  freeze, branch_taken, branch_addr, imem_data,
        output imem_addr, id_pc, id_instr, id_valid, fetch_count
    );

    modport slave (
        output freeze, branch_taken, branch_addr, imem_data,
        input  imem_addr, id_pc, id_instr, id_valid, fetch_count
    );
endinterface

// File: rtl/fetch_stage_pipe_reg_if_id.sv
// Generic pipeline register carrying PC+4, instruction and valid.
// Ports: clk, srst (sync active-high clear), freeze (hold), flush (sync
// clear to a bubble), in_* next values, out_* registered values.
// Priority: srst, flush, freeze, load.
module pipe_reg_if_id
    import fetch_stage_pkg::*;
#(
    parameter int                    WIDTH = DATA_WIDTH,
    parameter logic [WIDTH-1:0]      NOP   = NOP_INSTR
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             freeze,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_instr,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_instr,
    output logic             out_valid
);

    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] instr_reg;
    logic             valid_reg;

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            pc_reg    <= '0;
            instr_reg <= NOP;
            valid_reg <= 1'b0;
        end else if (!freeze) begin
            pc_reg    <= in_pc;
            instr_reg <= in_instr;
            valid_reg <= in_valid;
        end
    end

    assign out_pc    = pc_reg;
    assign out_instr = instr_reg;
    assign out_valid = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, presents it to the combinational
// instruction memory and latches instruction + PC+4 into IF/ID.
// Ports: clk, rst (sync active-high), bus (fetch_stage_if.master) carrying
// freeze/branch inputs, the imem address/data pair, IF/ID outputs and
// the count of valid instructions latched since reset.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    fetch_stage_if.master   bus
);

    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);

    fetch_mode_t           mode;
    logic [DATA_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] pc_plus_step;
    logic [31:0]           count_reg;
    logic [31:0]           count_next;

    // A redirect wins over a hazard hold; the wrong-path fetch is dropped.
    always_comb begin
        mode = MODE_RUN;
        if (bus.branch_taken) begin
            mode = MODE_REDIRECT;
        end else if (bus.freeze) begin
            mode = MODE_HOLD;
        end
    end

    // Wraps modulo 2^DATA_WIDTH by construction.
    assign pc_plus_step = pc_reg + STEP;

    always_comb begin
        pc_next    = pc_reg;
        count_next = count_reg;
        case (mode)
            MODE_RUN: begin
                pc_next    = pc_plus_step;
                count_next = count_reg + 32'd1;
            end
            MODE_REDIRECT: pc_next = bus.branch_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= RESET_PC;
            count_reg <= '0;
        end else begin
            pc_reg    <= pc_next;
            count_reg <= count_next;
        end
    end

    pipe_reg_if_id #(
        .WIDTH (DATA_WIDTH),
        .NOP   (NOP_INSTR)
    ) u_if_id (
        .clk       (clk),
        .srst      (rst),
        .freeze    (mode == MODE_HOLD),
        .flush     (mode == MODE_REDIRECT),
        .in_pc     (pc_plus_step),
        .in_instr  (bus.imem_data),
        .in_valid  (1'b1),
        .out_pc    (bus.id_pc),
        .out_instr (bus.id_instr),
        .out_valid (bus.id_valid)
    );

    assign bus.imem_addr   = pc_reg;
    assign bus.fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    logic [31:0] mem [0:63];

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational instruction memory, word-indexed.
    assign bus.imem_data = mem[bus.imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        // Intentionally unused: checks are inline per task.
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = '0;
        step();
        tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h exp %h", bus.imem_addr, 32'h0); end
        tests_run++; if (bus.id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", bus.id_valid); end
        tests_run++; if (bus.id_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got %h exp 0", bus.id_instr); end
        tests_run++; if (bus.id_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_idpc got %h exp 0", bus.id_pc); end
        tests_run++; if (bus.fetch_count !== 32'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", bus.fetch_count); end
        $display("[TB] reset: pc=%h count=%0d", bus.imem_addr, bus.fetch_count);
        rst = 1'b0;
    endtask

    task automatic test_run();
        tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL run_addr0 got %h exp 0", bus.imem_addr); end
        step();
        tests_run++; if (bus.imem_addr !== 32'h4) begin tests_failed++; $display("FAIL run_addr1 got %h exp 4", bus.imem_addr); end
        tests_run++; if (bus.id_instr !== 32'hE3A00014) begin tests_failed++; $display("FAIL run_instr1 got %h exp E3A00014", bus.id_instr); end
        tests_run++; if (bus.id_pc !== 32'h4) begin tests_failed++; $display("FAIL run_idpc1 got %h exp 4", bus.id_pc); end
        tests_run++; if (bus.id_valid !== 1'b1) begin tests_failed++; $display("FAIL run_valid1 got %b exp 1", bus.id_valid); end
        tests_run++; if (bus.fetch_count !== 32'd1) begin tests_failed++; $display("FAIL run_count1 got %0d exp 1", bus.fetch_count); end
        $display("[TB] run: id_instr=%h id_pc=%h", bus.id_instr, bus.id_pc);
        step();
        tests_run++; if (bus.imem_addr !== 32'h8) begin tests_failed++; $display("FAIL run_addr2 got %h exp 8", bus.imem_addr); end
        tests_run++; if (bus.id_instr !== 32'hE3A01A01) begin tests_failed++; $display("FAIL run_instr2 got %h exp E3A01A01", bus.id_instr); end
        tests_run++; if (bus.fetch_count !== 32'd2) begin tests_failed++; $display("FAIL run_count2 got %0d exp 2", bus.fetch_count); end
        $display("[TB] run: id_instr=%h id_pc=%h", bus.id_instr, bus.id_pc);
    endtask

    task automatic test_freeze();
        bus.freeze = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++; if (bus.imem_addr !== 32'h8) begin tests_failed++; $display("FAIL frz_addr got %h exp 8", bus.imem_addr); end
            tests_run++; if (bus.id_instr !== 32'hE3A01A01) begin tests_failed++; $display("FAIL frz_instr got %h exp E3A01A01", bus.id_instr); end
            tests_run++; if (bus.id_pc !== 32'h8) begin tests_failed++; $display("FAIL frz_idpc got %h exp 8", bus.id_pc); end
            tests_run++; if (bus.fetch_count !== 32'd2) begin tests_failed++; $display("FAIL frz_count got %0d exp 2", bus.fetch_count); end
            $display("[TB] freeze: pc=%h count=%0d", bus.imem_addr, bus.fetch_count);
        end
        bus.freeze = 1'b0;
        step();
        tests_run++; if (bus.id_instr !== 32'hE3A02103) begin tests_failed++; $display("FAIL frz_rel_instr got %h exp E3A02103", bus.id_instr); end
        tests_run++; if (bus.id_pc !== 32'hC) begin tests_failed++; $display("FAIL frz_rel_idpc got %h exp C", bus.id_pc); end
        tests_run++; if (bus.fetch_count !== 32'd3) begin tests_failed++; $display("FAIL frz_rel_count got %0d exp 3", bus.fetch_count); end
        $display("[TB] release: id_instr=%h id_pc=%h", bus.id_instr, bus.id_pc);
    endtask

    task automatic test_branch();
        bus.branch_taken = 1'b1; bus.branch_addr = 32'h94;
        step();
        tests_run++; if (bus.imem_addr !== 32'h94) begin tests_failed++; $display("FAIL br_setup got %h exp 94", bus.imem_addr); end
        bus.branch_addr = 32'h90;
        step();
        bus.branch_taken = 1'b0;
        tests_run++; if (bus.imem_addr !== 32'h90) begin tests_failed++; $display("FAIL br_addr got %h exp 90", bus.imem_addr); end
        tests_run++; if (bus.id_valid !== 1'b0) begin tests_failed++; $display("FAIL br_valid got %b exp 0", bus.id_valid); end
        tests_run++; if (bus.id_instr !== 32'h0) begin tests_failed++; $display("FAIL br_instr got %h exp 0", bus.id_instr); end
        tests_run++; if (bus.id_pc !== 32'h0) begin tests_failed++; $display("FAIL br_idpc got %h exp 0", bus.id_pc); end
        tests_run++; if (bus.fetch_count !== 32'd3) begin tests_failed++; $display("FAIL br_count got %0d exp 3", bus.fetch_count); end
        $display("[TB] branch: pc=%h valid=%b", bus.imem_addr, bus.id_valid);
        step();
        tests_run++; if (bus.id_instr !== 32'hE5901000) begin tests_failed++; $display("FAIL br_tgt_instr got %h exp E5901000", bus.id_instr); end
        tests_run++; if (bus.id_pc !== 32'h94) begin tests_failed++; $display("FAIL br_tgt_idpc got %h exp 94", bus.id_pc); end
        tests_run++; if (bus.id_valid !== 1'b1) begin tests_failed++; $display("FAIL br_tgt_valid got %b exp 1", bus.id_valid); end
        tests_run++; if (bus.fetch_count !== 32'd4) begin tests_failed++; $display("FAIL br_tgt_count got %0d exp 4", bus.fetch_count); end
        $display("[TB] target: id_instr=%h id_pc=%h", bus.id_instr, bus.id_pc);
    endtask

    task automatic test_freeze_branch();
        bus.freeze = 1'b1; bus.branch_taken = 1'b1; bus.branch_addr = 32'h4C;
        step();
        bus.freeze = 1'b0; bus.branch_taken = 1'b0;
        tests_run++; if (bus.imem_addr !== 32'h4C) begin tests_failed++; $display("FAIL fb_addr got %h exp 4C", bus.imem_addr); end
        tests_run++; if (bus.id_valid !== 1'b0) begin tests_failed++; $display("FAIL fb_valid got %b exp 0", bus.id_valid); end
        tests_run++; if (bus.fetch_count !== 32'd4) begin tests_failed++; $display("FAIL fb_count got %0d exp 4", bus.fetch_count); end
        $display("[TB] freeze+branch: pc=%h valid=%b", bus.imem_addr, bus.id_valid);
    endtask

    task automatic test_reset_mid();
        step();
        tests_run++; if (bus.fetch_count !== 32'd5) begin tests_failed++; $display("FAIL rm_pre_count got %0d exp 5", bus.fetch_count); end
        rst = 1'b1; bus.freeze = 1'b1; bus.branch_taken = 1'b1; bus.branch_addr = 32'h80;
        step();
        rst = 1'b0; bus.freeze = 1'b0; bus.branch_taken = 1'b0;
        tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL rm_addr got %h exp 0", bus.imem_addr); end
        tests_run++; if (bus.id_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_valid got %b exp 0", bus.id_valid); end
        tests_run++; if (bus.id_instr !== 32'h0) begin tests_failed++; $display("FAIL rm_instr got %h exp 0", bus.id_instr); end
        tests_run++; if (bus.fetch_count !== 32'd0) begin tests_failed++; $display("FAIL rm_count got %0d exp 0", bus.fetch_count); end
        $display("[TB] reset mid: pc=%h count=%0d", bus.imem_addr, bus.fetch_count);
        step();
        tests_run++; if (bus.id_instr !== 32'hE3A00014) begin tests_failed++; $display("FAIL rm_next_instr got %h exp E3A00014", bus.id_instr); end
        tests_run++; if (bus.id_pc !== 32'h4) begin tests_failed++; $display("FAIL rm_next_idpc got %h exp 4", bus.id_pc); end
        tests_run++; if (bus.fetch_count !== 32'd1) begin tests_failed++; $display("FAIL rm_next_count got %0d exp 1", bus.fetch_count); end
        $display("[TB] after reset: id_instr=%h id_pc=%h", bus.id_instr, bus.id_pc);
    endtask

    task automatic test_spin();
        bus.branch_taken = 1'b1; bus.branch_addr = 32'hB8;
        for (int i = 0; i < 20; i++) begin
            step();
            tests_run++; if (bus.imem_addr !== 32'hB8) begin tests_failed++; $display("FAIL spin_addr[%0d] got %h exp B8", i, bus.imem_addr); end
            tests_run++; if (bus.id_valid !== 1'b0) begin tests_failed++; $display("FAIL spin_valid[%0d] got %b exp 0", i, bus.id_valid); end
            tests_run++; if (bus.fetch_count !== 32'd1) begin tests_failed++; $display("FAIL spin_count[%0d] got %0d exp 1", i, bus.fetch_count); end
            $display("[TB] spin %0d: pc=%h valid=%b", i, bus.imem_addr, bus.id_valid);
        end
        bus.branch_taken = 1'b0;
        step();
        tests_run++; if (bus.id_instr !== 32'hE000002E) begin tests_failed++; $display("FAIL spin_exit_instr got %h exp E000002E", bus.id_instr); end
        tests_run++; if (bus.id_pc !== 32'hBC) begin tests_failed++; $display("FAIL spin_exit_idpc got %h exp BC", bus.id_pc); end
        tests_run++; if (bus.fetch_count !== 32'd2) begin tests_failed++; $display("FAIL spin_exit_count got %0d exp 2", bus.fetch_count); end
        $display("[TB] spin exit: id_instr=%h id_pc=%h", bus.id_instr, bus.id_pc);
    endtask

    task automatic test_back_to_back();
        bus.branch_taken = 1'b1; bus.branch_addr = 32'h10;
        step();
        bus.branch_addr = 32'h20;
        step();
        bus.branch_taken = 1'b0;
        tests_run++; if (bus.imem_addr !== 32'h20) begin tests_failed++; $display("FAIL b2b_addr got %h exp 20", bus.imem_addr); end
        step();
        tests_run++; if (bus.id_instr !== 32'hE0000008) begin tests_failed++; $display("FAIL b2b_instr got %h exp E0000008", bus.id_instr); end
        tests_run++; if (bus.id_pc !== 32'h24) begin tests_failed++; $display("FAIL b2b_idpc got %h exp 24", bus.id_pc); end
        tests_run++; if (bus.fetch_count !== 32'd3) begin tests_failed++; $display("FAIL b2b_count got %0d exp 3", bus.fetch_count); end
        $display("[TB] back-to-back: id_instr=%h id_pc=%h", bus.id_instr, bus.id_pc);
    endtask

    task automatic test_wrap();
        bus.branch_taken = 1'b1; bus.branch_addr = 32'hFFFF_FFFC;
        step();
        bus.branch_taken = 1'b0;
        step();
        tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_addr got %h exp 0", bus.imem_addr); end
        tests_run++; if (bus.id_pc !== 32'h0) begin tests_failed++; $display("FAIL wrap_idpc got %h exp 0", bus.id_pc); end
        tests_run++; if (bus.id_instr !== 32'hE000003F) begin tests_failed++; $display("FAIL wrap_instr got %h exp E000003F", bus.id_instr); end
        tests_run++; if (bus.id_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_valid got %b exp 1", bus.id_valid); end
        $display("[TB] wrap: pc=%h id_pc=%h", bus.imem_addr, bus.id_pc);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hE000_0000 | 32'(i);
        mem[0]  = 32'hE3A00014;
        mem[1]  = 32'hE3A01A01;
        mem[2]  = 32'hE3A02103;
        mem[36] = 32'hE5901000;
        rst = 1'b1;
        bus.freeze = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr = '0;
        #2;
        test_reset();
        test_run();
        test_freeze();
        test_branch();
        test_freeze_branch();
        test_reset_mid();
        test_spin();
        test_back_to_back();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
